icache_ctrl: RTL and testbench

Direct-mapped, read-only cache controller that sequences one external word-wide data RAM (registered read, byte-masked write, `ADDR_WIDTH` = `INDEX_WIDTH`, 4 data bytes) on behalf of the instruction-fetch stage. It owns the tag and valid arrays, decides hit or miss, and fetches missing words from the memory interface over a req/ack handshake. It fills the RAM and returns one word per accepted request. It sits between IF and the memory controller.

---
 rtl/icache_ctrl_if.sv | 37 +++
 rtl/icache_ctrl.sv | 116 +++++++++++
 tb/tb_icache_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_ctrl_if.sv
// Bus bundle for icache_ctrl: fetch request/response, memory read channel and
// the external data RAM ports. The cache controller uses the master modport.
interface icache_ctrl_if #(
  parameter int INDEX_WIDTH = 8
);
  logic                   req_valid;
  logic [31:0]            req_addr;
  logic                   req_ready;
  logic                   resp_valid;
  logic [31:0]            resp_data;
  logic                   flush;

  logic                   mem_req;
  logic [31:0]            mem_addr;
  logic                   mem_ack;
  logic [31:0]            mem_rdata;

  logic                   ram_r_flag;
  logic [INDEX_WIDTH-1:0] ram_r_addr;
  logic [31:0]            ram_r_data;
  logic                   ram_w_flag;
  logic [INDEX_WIDTH-1:0] ram_w_addr;
  logic [31:0]            ram_w_data;
  logic [3:0]             ram_w_mask;

  modport master (
    input  req_valid, req_addr, flush, mem_ack, mem_rdata, ram_r_data,
    output req_ready, resp_valid, resp_data, mem_req, mem_addr,
           ram_r_flag, ram_r_addr, ram_w_flag, ram_w_addr, ram_w_data, ram_w_mask
  );

  modport slave (
    output req_valid, req_addr, flush, mem_ack, mem_rdata, ram_r_data,
    input  req_ready, resp_valid, resp_data, mem_req, mem_addr,
           ram_r_flag, ram_r_addr, ram_w_flag, ram_w_addr, ram_w_data, ram_w_mask
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller: tag/valid arrays,
// hit/miss decision, miss fetch over req/ack and refill of an external data RAM.
module icache_ctrl #(
  parameter int INDEX_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  icache_ctrl_if.master bus
);
  localparam int TAG_WIDTH = 30 - INDEX_WIDTH;
  localparam int LINES     = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, FILL} state_t;

  state_t                 state_q, state_d;
  logic [29:0]            line_addr_q, line_addr_d;
  logic [31:0]            word_q, word_d;
  logic                   drop_q, drop_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [TAG_WIDTH-1:0]   tag_q [LINES];

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_WIDTH-1:0]   tag;
  logic                   hit;
  logic                   accept;

  assign idx    = line_addr_q[INDEX_WIDTH-1:0];
  assign tag    = line_addr_q[29:INDEX_WIDTH];
  // Evaluated on the registered valid bits, so a flush in LOOKUP still hits.
  assign hit    = valid_q[idx] && (tag_q[idx] == tag);
  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d        = state_q;
    line_addr_d    = line_addr_q;
    word_d         = word_q;
    drop_d         = drop_q;
    valid_d        = valid_q;
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    bus.mem_req    = 1'b0;
    bus.mem_addr   = '0;
    bus.ram_r_flag = 1'b0;
    bus.ram_r_addr = '0;
    bus.ram_w_flag = 1'b0;
    bus.ram_w_addr = '0;
    bus.ram_w_data = '0;
    bus.ram_w_mask = '0;

    if (bus.flush) valid_d = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          line_addr_d    = bus.req_addr[31:2];
          bus.ram_r_flag = 1'b1;
          bus.ram_r_addr = bus.req_addr[INDEX_WIDTH+1:2];
          state_d        = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          bus.resp_valid = 1'b1;
          bus.resp_data  = bus.ram_r_data;
          state_d        = IDLE;
        end else begin
          state_d = MISS;
        end
      end
      MISS: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {line_addr_q, 2'b00};
        if (bus.flush) drop_d = 1'b1;
        if (bus.mem_ack) begin
          word_d  = bus.mem_rdata;
          state_d = FILL;
        end
      end
      FILL: begin
        bus.ram_w_flag = 1'b1;
        bus.ram_w_addr = idx;
        bus.ram_w_data = word_q;
        bus.ram_w_mask = 4'hF;
        bus.resp_valid = 1'b1;
        bus.resp_data  = word_q;
        // A flush that overlapped the fetch must leave the refilled line invalid.
        if (!drop_q && !bus.flush) valid_d[idx] = 1'b1;
        drop_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      word_q      <= '0;
      drop_q      <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      word_q      <= word_d;
      drop_q      <= drop_d;
      valid_q     <= valid_d;
    end
  end

  // Tags need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (state_q == FILL) tag_q[idx] <= tag;
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios followed by random
// fetches, checked against a line-level valid/tag model and a backing memory.
module tb_icache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  icache_ctrl_if #(.INDEX_WIDTH(8)) bus ();
  icache_ctrl #(.INDEX_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  // External data RAM: registered read, byte-masked write.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (bus.ram_r_flag) bus.ram_r_data <= ram[bus.ram_r_addr];
    if (bus.ram_w_flag)
      for (int b = 0; b < 4; b++)
        if (bus.ram_w_mask[b]) ram[bus.ram_w_addr][8*b +: 8] <= bus.ram_w_data[8*b +: 8];
  end

  // Reference model: which lines hold which tag, and what main memory contains.
  bit          mvalid [256];
  logic [21:0] mtag   [256];
  logic [31:0] ovr    [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (ovr.exists(w)) return ovr[w];
    return w * 32'h9E37_79B1 + 32'h5A5A_0F0F;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One fetch. Flush options: with the request, during LOOKUP, or during MISS.
  task automatic fetch(input logic [31:0] addr, input bit fl_req, input bit fl_look,
                       input bit fl_miss, input int dly);
    logic [7:0]  idx;
    logic [21:0] tg;
    logic [31:0] word;
    bit          hit;
    idx  = addr[9:2];
    tg   = addr[31:10];
    word = mem_word(addr);
    if (fl_req) clear_model();
    hit = mvalid[idx] && (mtag[idx] == tg);

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.flush     = fl_req;
    #1;
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    chk("ram_r_flag", 32'(bus.ram_r_flag), 32'd1);
    chk("ram_r_addr", 32'(bus.ram_r_addr), 32'(idx));

    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.flush     = fl_look;
    #1;
    chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
    if (fl_look) clear_model();
    if (hit) begin
      chk("hit_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("hit_resp_data", bus.resp_data, word);
      chk("hit_no_mem_req", 32'(bus.mem_req), 32'd0);
    end else begin
      chk("lookup_no_resp", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      bus.flush = fl_miss;
      #1;
      chk("miss_mem_req", 32'(bus.mem_req), 32'd1);
      chk("miss_mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("wait_mem_req", 32'(bus.mem_req), 32'd1);
        chk("wait_no_resp", 32'(bus.resp_valid), 32'd0);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = word;
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.flush     = 1'b0;
      bus.mem_rdata = $urandom;
      #1;
      chk("fill_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("fill_resp_data", bus.resp_data, word);
      chk("fill_w_flag", 32'(bus.ram_w_flag), 32'd1);
      chk("fill_w_addr", 32'(bus.ram_w_addr), 32'(idx));
      chk("fill_w_data", bus.ram_w_data, word);
      chk("fill_w_mask", 32'(bus.ram_w_mask), 32'hF);
      chk("fill_mem_req_low", 32'(bus.mem_req), 32'd0);
      chk("fill_no_read", 32'(bus.ram_r_flag), 32'd0);
      if (fl_miss) clear_model();
      mtag[idx]   = tg;
      mvalid[idx] = !fl_miss;
    end
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("back_idle", 32'(bus.req_ready), 32'd1);
    chk("idle_no_resp", 32'(bus.resp_valid), 32'd0);
    $display("fetch addr=%h %s flush=%0d%0d%0d data=%h", addr, hit ? "hit " : "miss",
             fl_req, fl_look, fl_miss, word);
  endtask

  task automatic flush_idle();
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    clear_model();
    $display("flush in idle");
  endtask

  task automatic reset_mid_miss(input logic [31:0] addr);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("rmm_lookup_miss", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("rmm_mem_req", 32'(bus.mem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rmm_mem_req_drop", 32'(bus.mem_req), 32'd0);
    chk("rmm_mem_addr", bus.mem_addr, 32'd0);
    chk("rmm_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rmm_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD0_0BAD;
    #1;
    chk("late_ack_no_resp", 32'(bus.resp_valid), 32'd0);
    chk("late_ack_no_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("late_ack_no_resp2", 32'(bus.resp_valid), 32'd0);
    chk("late_ack_no_write", 32'(bus.ram_w_flag), 32'd0);
    $display("reset during miss addr=%h", addr);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  ri;
    int          pick;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    clear_model();
    ovr[32'h0000_1004] = 32'hDEAD_BEEF;
    ovr[32'h0000_2008] = 32'h1234_5678;

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_ram_w_flag", 32'(bus.ram_w_flag), 32'd0);
    chk("rst_ram_r_flag", 32'(bus.ram_r_flag), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

    fetch(32'h0000_1004, 0, 0, 0, 3);   // cold miss
    fetch(32'h0000_1004, 0, 0, 0, 0);   // hit
    fetch(32'h0000_1404, 0, 0, 0, 1);   // conflict refill
    fetch(32'h0000_1004, 0, 0, 0, 2);   // evicted, misses again
    fetch(32'h0000_1004, 0, 0, 0, 0);
    flush_idle();
    fetch(32'h0000_1004, 0, 0, 0, 0);   // miss after flush
    fetch(32'h0000_1004, 0, 1, 0, 0);   // hit, flush in LOOKUP
    fetch(32'h0000_1004, 1, 0, 0, 1);   // flush with request: miss
    fetch(32'h0000_2008, 0, 0, 1, 2);   // flush during MISS drops the line
    fetch(32'h0000_2008, 0, 0, 0, 0);   // must miss
    fetch(32'h0000_2008, 0, 0, 0, 0);   // drop cleared: now hits
    reset_mid_miss(32'h0000_3000);
    fetch(32'h0000_3000, 0, 0, 0, 1);
    fetch(32'h0000_1004, 0, 0, 0, 0);   // reset cleared valids

    for (int n = 0; n < 60; n++) begin
      pick = int'($urandom_range(0, 3));
      ri   = (pick == 3) ? 8'hFF : 8'(pick + 1);
      a    = {22'($urandom_range(4, 6)), ri, 2'($urandom)};
      fetch(a, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
